reset_ctrl: RTL



---
 rtl/reset_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/reset_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared types and defaults for the reset controller and its helpers.
// The optional completed-reset counter is enabled with the RESET_CNT_EN macro.
package reset_pkg;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 8;
    localparam int RST_CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        DONE,
        RELEASE
    } rst_state_t;

endpackage : reset_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, async active-high reset.
// Adds two clock cycles of latency; q is safe to use in the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so both flops
        // sample their inputs from before the edge, forming a real shift chain.
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/reset_ctrl.sv
// Reset request responder: synchronises and debounces an enable-qualified
// request, drives a stretched registered sys_reset, then pulses done.
// Optional completed-reset counter on rst_count when RESET_CNT_EN is defined.
module reset_ctrl
    import reset_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 req,
    output logic                 sys_reset,
    output logic                 busy,
    output logic                 done,
    output logic [RST_CNT_W-1:0] rst_count
);

    // The cycle counter must hold both limits so it can never wrap.
    if (CNT_W < 1 || CNT_W > 30 || DEB_CYCLES < 1 || HOLD_CYCLES < 1 ||
        DEB_CYCLES >= (1 << CNT_W) || HOLD_CYCLES >= (1 << CNT_W)) begin : g_param_check
        $error("reset_ctrl: CNT_W too small for DEB_CYCLES/HOLD_CYCLES, or a count below 1");
    end

    localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES);

    rst_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             req_s;

    sync_2ff u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Next-state and counter decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (en && req_s) begin
                    state_nx = DEBOUNCE;
                    cnt_nx   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!req_s || !en) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DEB_LIMIT) begin
                    state_nx = HOLD;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                // Not abortable: en and req are deliberately ignored here.
                if (cnt == HOLD_LIMIT) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = RELEASE;
            end
            RELEASE: begin
                // A held request yields one reset; wait for it to be released.
                if (!req_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Moore outputs registered from the next state so they are glitch-free
    // and change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sys_reset <= (state_nx == HOLD);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
        end
    end

`ifdef RESET_CNT_EN
    logic [RST_CNT_W-1:0] done_cnt;

    // Count entries into DONE, saturating at all-ones; cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (state_nx == DONE && state != DONE && done_cnt != '1) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

    assign rst_count = done_cnt;
`else
    assign rst_count = '0;
`endif

endmodule : reset_ctrl
